// File: rtl/pipeline_pkg.sv
// Shared fetch/decode definitions: bubble marker and the {pc, instruction} entry layout.
package pipeline_pkg;

  localparam int unsigned FQ_ADDR_WIDTH = 64;
  localparam int unsigned FQ_INSN_WIDTH = 32;

  localparam logic [FQ_INSN_WIDTH-1:0] BUBBLE_INSN = 32'd90;

  typedef struct packed {
    logic [FQ_ADDR_WIDTH-1:0] pc;
    logic [FQ_INSN_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/pipeline_fetch_queue_if.sv
// Fetch-to-decode handshake bundle; master drives fetch/decode controls, slave is the queue.
interface pipeline_fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned INSN_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) ();
  logic                     in_valid;
  logic [ADDR_WIDTH-1:0]    in_pc;
  logic [INSN_WIDTH-1:0]    in_instruction;
  logic                     in_ready;
  logic                     out_valid;
  logic [ADDR_WIDTH-1:0]    out_pc;
  logic [INSN_WIDTH-1:0]    out_instruction;
  logic                     out_ready;
  logic                     flush;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_pc, in_instruction, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instruction, count
  );

  modport slave (
    input  in_valid, in_pc, in_instruction, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instruction, count
  );
endinterface

// File: rtl/pipeline_fifo_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
module pipeline_fifo_mem
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);
  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/pipeline_fetch_queue.sv
// In-order fetch->decode queue dropping bubbles, with flush.
// Optional 0-cycle path when empty: `define PIPELINE_FETCH_QUEUE_BYPASS_EN.
module pipeline_fetch_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FQ_ADDR_WIDTH,
  parameter int unsigned INSN_WIDTH = FQ_INSN_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_fetch_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, rd_idx;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mirror_q, mirror_d, in_entry, rd_data;
  logic          not_bubble, in_ready, head_valid, push, pop, wr_en;
`ifdef PIPELINE_FETCH_QUEUE_BYPASS_EN
  logic          bypass;
`endif

  pipeline_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (tail_q),
    .wdata (in_entry),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_comb begin
    in_entry.pc          = FQ_ADDR_WIDTH'(bus.in_pc);
    in_entry.instruction = FQ_INSN_WIDTH'(bus.in_instruction);
    not_bubble = (bus.in_instruction != BUBBLE_INSN);
    in_ready   = (count_q != CW'(DEPTH));
    head_valid = (count_q != '0);
    push       = bus.in_valid && in_ready && !bus.flush && not_bubble;
    pop        = head_valid && bus.out_ready && !bus.flush;
    rd_idx     = head_q + PW'(1);
`ifdef PIPELINE_FETCH_QUEUE_BYPASS_EN
    bypass     = (count_q == '0) && bus.in_valid && not_bubble && !bus.flush;
    wr_en      = push && !(bypass && bus.out_ready);
`else
    wr_en      = push;
`endif
  end

  // mirror_q tracks the entry that will sit at head after this edge, so out_* stay registered
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    mirror_d = mirror_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PW'(1);
      if (pop)   head_d = head_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);
      if (wr_en && ((count_q == '0) || (pop && count_q == CW'(1))))
        mirror_d = in_entry;
      else if (pop && count_q > CW'(1))
        mirror_d = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q               <= '0;
      tail_q               <= '0;
      count_q              <= '0;
      mirror_q.pc          <= '0;
      mirror_q.instruction <= BUBBLE_INSN;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      mirror_q <= mirror_d;
    end
  end

  always_comb begin
    bus.in_ready        = in_ready;
    bus.count           = count_q;
    bus.out_valid       = head_valid;
    bus.out_pc          = ADDR_WIDTH'(mirror_q.pc);
    bus.out_instruction = INSN_WIDTH'(mirror_q.instruction);
`ifdef PIPELINE_FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      bus.out_valid       = 1'b1;
      bus.out_pc          = bus.in_pc;
      bus.out_instruction = bus.in_instruction;
    end
`endif
  end
endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Bench for pipeline_fetch_queue: directed table, hand sequences, random vs queue model.
module tb_pipeline_fetch_queue;
  import pipeline_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_fetch_queue_if #(.ADDR_WIDTH(64), .INSN_WIDTH(32), .DEPTH(DEPTH)) bus ();

  pipeline_fetch_queue #(.ADDR_WIDTH(64), .INSN_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
  } ment_t;
  ment_t mq[$];

  typedef struct {
    logic        in_valid;
    logic [63:0] pc;
    logic [31:0] insn;
    logic        out_ready;
    logic        flush;
    int          exp_count;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic        exp_ready;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] insn,
                       input logic ordy, input logic fl);
    bus.in_valid       = v;
    bus.in_pc          = pc;
    bus.in_instruction = insn;
    bus.out_ready      = ordy;
    bus.flush          = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 32'h13, 1'b0, 1'b0);
  endtask

  // Reference: queue semantics taken straight from the push/pop/flush rules
  task automatic model_step();
    bit nb, byp, pop, push;
    ment_t e;
    if (reset || bus.flush) begin
      mq.delete();
    end else begin
      nb  = (bus.in_instruction != 32'd90);
      byp = 1'b0;
`ifdef PIPELINE_FETCH_QUEUE_BYPASS_EN
      byp = (mq.size() == 0) && bus.in_valid && nb && bus.out_ready;
`endif
      pop  = (mq.size() > 0) && bus.out_ready;
      push = bus.in_valid && (mq.size() != DEPTH) && nb && !byp;
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc   = bus.in_pc;
        e.insn = bus.in_instruction;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    logic        ev;
    logic [63:0] epc;
    logic [31:0] ein;
    ev  = (mq.size() != 0);
    epc = ev ? mq[0].pc : '0;
    ein = ev ? mq[0].insn : '0;
`ifdef PIPELINE_FETCH_QUEUE_BYPASS_EN
    if (mq.size() == 0 && bus.in_valid && bus.in_instruction != 32'd90 && !bus.flush) begin
      ev  = 1'b1;
      epc = bus.in_pc;
      ein = bus.in_instruction;
    end
`endif
    chk("rnd_count", 64'(bus.count), 64'(mq.size()));
    chk("rnd_in_ready", 64'(bus.in_ready), 64'(mq.size() != DEPTH));
    chk("rnd_out_valid", 64'(bus.out_valid), 64'(ev));
    if (ev) begin
      chk("rnd_out_pc", bus.out_pc, epc);
      chk("rnd_out_insn", 64'(bus.out_instruction), 64'(ein));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [63:0] pc, logic [31:0] insn, logic ordy, logic fl,
                              int ec, logic evld, logic [63:0] epc, logic erdy);
    vec_t r;
    r.in_valid = v;  r.pc = pc;  r.insn = insn;  r.out_ready = ordy;  r.flush = fl;
    r.exp_count = ec;  r.exp_valid = evld;  r.exp_pc = epc;  r.exp_ready = erdy;
    return r;
  endfunction

  initial begin
    vecs.push_back(mk(1, 64'h1000, 32'h13, 0, 0, 1, 1, 64'h1000, 1));
    vecs.push_back(mk(0, 64'h0,    32'h13, 1, 0, 0, 0, 64'h0,    1));
    vecs.push_back(mk(1, 64'h0,    32'h13, 0, 0, 1, 1, 64'h0,    1));
    vecs.push_back(mk(1, 64'h4,    32'h13, 0, 0, 2, 1, 64'h0,    1));
    vecs.push_back(mk(1, 64'h8,    32'h13, 0, 0, 3, 1, 64'h0,    1));
    vecs.push_back(mk(1, 64'hC,    32'h13, 0, 0, 4, 1, 64'h0,    0));
    vecs.push_back(mk(1, 64'h10,   32'h13, 0, 0, 4, 1, 64'h0,    0));
    vecs.push_back(mk(1, 64'h10,   32'h13, 1, 0, 3, 1, 64'h4,    1));
    vecs.push_back(mk(0, 64'h0,    32'h13, 1, 0, 2, 1, 64'h8,    1));
    vecs.push_back(mk(0, 64'h0,    32'h13, 1, 0, 1, 1, 64'hC,    1));
    vecs.push_back(mk(0, 64'h0,    32'h13, 1, 0, 0, 0, 64'h0,    1));
    vecs.push_back(mk(1, 64'h50,   32'd90, 0, 0, 0, 0, 64'h0,    1));
    vecs.push_back(mk(1, 64'h100,  32'h13, 0, 0, 1, 1, 64'h100,  1));
    vecs.push_back(mk(1, 64'h104,  32'h13, 0, 0, 2, 1, 64'h100,  1));
    vecs.push_back(mk(1, 64'h108,  32'h13, 0, 0, 3, 1, 64'h100,  1));
    vecs.push_back(mk(1, 64'h10C,  32'h13, 0, 1, 0, 0, 64'h0,    1));
    vecs.push_back(mk(1, 64'h2000, 32'h13, 0, 0, 1, 1, 64'h2000, 1));
    vecs.push_back(mk(0, 64'h0,    32'h13, 1, 0, 0, 0, 64'h0,    1));

    reset = 1'b1;
    idle();
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_pc", bus.out_pc, 64'd0);
    chk("reset_out_insn", 64'(bus.out_instruction), 64'd90);

    foreach (vecs[i]) begin
      drive(vecs[i].in_valid, vecs[i].pc, vecs[i].insn, vecs[i].out_ready, vecs[i].flush);
      cycle();
      idle();
      #1;
      chk($sformatf("vec%0d_count", i), 64'(bus.count), 64'(vecs[i].exp_count));
      chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ready));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_out_pc", i), bus.out_pc, vecs[i].exp_pc);
    end

`ifdef PIPELINE_FETCH_QUEUE_BYPASS_EN
    drive(1'b1, 64'h40, 32'h13, 1'b1, 1'b0);
    #1;
    chk("bypass_out_valid", 64'(bus.out_valid), 64'd1);
    chk("bypass_out_pc", bus.out_pc, 64'h40);
    cycle();
    idle();
    #1;
    chk("bypass_count", 64'(bus.count), 64'd0);
    chk("bypass_after_valid", 64'(bus.out_valid), 64'd0);
`endif

    // steady push+pop with one entry resident, long enough to wrap the pointers
    drive(1'b1, 64'h3000, 32'h13, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h3000 + 64'(4 * (i + 1)), 32'h13 + 32'(i), 1'b1, 1'b0);
      #1;
      chk($sformatf("wrap%0d_out_pc", i), bus.out_pc, 64'h3000 + 64'(4 * i));
      cycle();
      chk($sformatf("wrap%0d_count", i), 64'(bus.count), 64'd1);
    end
    drive(1'b0, '0, 32'h13, 1'b1, 1'b0);
    cycle();
    idle();
    #1;
    chk("wrap_drained", 64'(bus.count), 64'd0);

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0,
            {$urandom, $urandom},
            ($urandom_range(0, 5) == 0) ? 32'd90 : $urandom,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
      #1;
      check_model();
      cycle();
    end
    reset = 1'b0;
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
